// File: rtl/uart_cfg_loader_if.sv
// ============================================================================
// Module  : uart_cfg_loader_if
// Brief   : Serial-in / config-write-out signal bundle for uart_cfg_loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cfg_loader_if;
    logic        Rx;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
    logic        ReceiveLED;
    logic        FrameError;

    // The loader is the slave: it consumes Rx and produces the config writes.
    modport slave (
        input  Rx,
        output WriteData,
        output WriteStrobe,
        output ComActive,
        output ReceiveLED,
        output FrameError
    );

    modport master (
        output Rx,
        input  WriteData,
        input  WriteStrobe,
        input  ComActive,
        input  ReceiveLED,
        input  FrameError
    );
endinterface

`default_nettype wire

// File: rtl/uart_cfg_loader.sv
// ============================================================================
// Module  : uart_cfg_loader
// Brief   : 8N1 UART bitstream receiver that hunts a sync word, then packs
//           bytes MSB-first into 32-bit config words with one-cycle strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cfg_loader #(
    parameter int          CLKS_PER_BIT = 8,
    parameter logic [31:0] SYNC_WORD    = 32'hFAB0_FAB1,
    parameter int          TIMEOUT_CLKS = 4096
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    uart_cfg_loader_if.slave  bus
);

    localparam int               c_PW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_PW-1:0]  c_HALF    = c_PW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_PW-1:0]  c_FULL    = c_PW'(CLKS_PER_BIT - 1);
    localparam int               c_TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_TW-1:0]  c_TO_LAST = c_TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        r_state;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic [c_PW-1:0]  r_phase;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;

    logic [23:0]      r_win;
    logic             r_synced;
    logic [1:0]       r_byte_cnt;
    logic [23:0]      r_word;
    logic [31:0]      r_wdata;
    logic             r_wstrobe;
    logic [c_TW-1:0]  r_to_cnt;

    logic             w_start_det;
    logic [31:0]      w_win_next;

    // Edge detect on the synchronised line; after a framing error the line
    // must return high before another start can be seen.
    assign w_start_det = (r_state == S_IDLE) && r_rx_prev && !r_rx_sync;
    assign w_win_next  = {r_win, r_shift};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= bus.Rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_phase <= '0;
                    if (w_start_det) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_phase == c_HALF) begin
                        r_phase <= '0;
                        if (!r_rx_sync) begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_phase == c_FULL) begin
                        r_phase <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_phase == c_FULL) begin
                        r_phase <= '0;
                        r_state <= S_IDLE;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sync hunting, word packing and idle timeout. The shift register holds
    // the completed byte during the byte_valid cycle since IDLE never shifts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_win      <= '0;
            r_synced   <= 1'b0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_wstrobe  <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_wstrobe <= 1'b0;
            if (!r_synced) begin
                r_to_cnt <= '0;
                if (r_byte_valid) begin
                    r_win <= w_win_next[23:0];
                    if (w_win_next == SYNC_WORD) begin
                        r_synced   <= 1'b1;
                        r_byte_cnt <= '0;
                    end
                end
            end else begin
                if (w_start_det) begin
                    r_to_cnt <= '0;
                end else if (r_state == S_IDLE) begin
                    if (r_to_cnt == c_TO_LAST) begin
                        r_synced   <= 1'b0;
                        r_to_cnt   <= '0;
                        r_win      <= '0;
                        r_byte_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                if (r_byte_valid) begin
                    if (r_byte_cnt == 2'd3) begin
                        r_wdata    <= {r_word, r_shift};
                        r_wstrobe  <= 1'b1;
                        r_byte_cnt <= '0;
                    end else begin
                        r_word     <= {r_word[15:0], r_shift};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
            end
        end
    end

    assign bus.WriteData   = r_wdata;
    assign bus.WriteStrobe = r_wstrobe;
    assign bus.ComActive   = r_synced;
    assign bus.ReceiveLED  = (r_state != S_IDLE);
    assign bus.FrameError  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_cfg_loader.sv
// ============================================================================
// Module  : tb_uart_cfg_loader
// Brief   : Directed self-checking bench for uart_cfg_loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cfg_loader;

    localparam int c_CPB = 8;

    logic CLK;
    logic RST;

    uart_cfg_loader_if bus ();

    uart_cfg_loader #(
        .CLKS_PER_BIT (c_CPB),
        .SYNC_WORD    (32'hFAB0_FAB1),
        .TIMEOUT_CLKS (4096)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks   = 0;
    int n_failures = 0;

    // Activity monitor: cumulative totals only, the main flow takes deltas.
    int          cyc          = 0;
    int          strobe_total = 0;
    int          strobe_wide  = 0;
    int          fe_total     = 0;
    int          led_rises    = 0;
    int          led_fall_cyc = 0;
    int          strobe_cyc   = 0;
    int          com_rise_cyc = 0;
    logic [31:0] last_data    = '0;
    logic        strobe_prev  = 1'b0;
    logic        led_prev     = 1'b0;
    logic        com_prev     = 1'b0;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (bus.WriteStrobe === 1'b1) begin
            strobe_total = strobe_total + 1;
            last_data    = bus.WriteData;
            strobe_cyc   = cyc;
            if (strobe_prev) strobe_wide = strobe_wide + 1;
        end
        if (bus.ReceiveLED === 1'b1 && !led_prev) led_rises = led_rises + 1;
        if (bus.ReceiveLED === 1'b0 && led_prev) led_fall_cyc = cyc;
        if (bus.ComActive === 1'b1 && !com_prev) com_rise_cyc = cyc;
        if (bus.FrameError === 1'b1) fe_total = fe_total + 1;
        strobe_prev = (bus.WriteStrobe === 1'b1);
        led_prev    = (bus.ReceiveLED === 1'b1);
        com_prev    = (bus.ComActive === 1'b1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_failures = n_failures + 1;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        wait_clks(3);
        RST = 1'b0;
        wait_clks(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.Rx = 1'b0;
        wait_clks(c_CPB);
        for (int i = 0; i < 8; i++) begin
            bus.Rx = b[i];
            wait_clks(c_CPB);
        end
        bus.Rx = stop_bit;
        wait_clks(c_CPB);
        bus.Rx = 1'b1;
        wait_clks(c_CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8],  1'b1);
        send_byte(w[7:0],   1'b1);
    endtask

    int s0, f0, l0;

    initial begin
        RST    = 1'b1;
        bus.Rx = 1'b1;
        wait_clks(3);
        check_eq("rst_wdata",  bus.WriteData,   32'h0);
        check_eq("rst_strobe", bus.WriteStrobe, 32'h0);
        check_eq("rst_com",    bus.ComActive,   32'h0);
        check_eq("rst_led",    bus.ReceiveLED,  32'h0);
        check_eq("rst_fe",     bus.FrameError,  32'h0);
        RST = 1'b0;

        // Idle line
        wait_clks(10000);
        check_eq("idle_strobes", strobe_total, 0);
        check_eq("idle_com",     bus.ComActive, 32'h0);

        // Sync then one word
        s0 = strobe_total; l0 = led_rises;
        send_word(32'hFAB0_FAB1);
        check_eq("sync_com",      bus.ComActive, 32'h1);
        check_eq("sync_com_lat",  com_rise_cyc - led_fall_cyc, 1);
        check_eq("sync_nostrobe", strobe_total - s0, 0);
        send_word(32'h1234_5678);
        check_eq("w1_count",  strobe_total - s0, 1);
        check_eq("w1_data",   last_data, 32'h1234_5678);
        check_eq("w1_lat",    strobe_cyc - led_fall_cyc, 1);
        check_eq("w1_led",    led_rises - l0, 8);

        // Sliding-window sync after garbage
        do_reset();
        check_eq("rst2_com", bus.ComActive, 32'h0);
        s0 = strobe_total;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFA, 1'b1);
        send_byte(8'hB0, 1'b1);
        send_word(32'hFAB0_FAB1);
        check_eq("g_nostrobe", strobe_total - s0, 0);
        check_eq("g_com",      bus.ComActive, 32'h1);
        send_word(32'hAABB_CCDD);
        check_eq("g_count", strobe_total - s0, 1);
        check_eq("g_data",  last_data, 32'hAABB_CCDD);

        // Framing error mid-word
        do_reset();
        s0 = strobe_total; f0 = fe_total;
        send_word(32'hFAB0_FAB1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h55, 1'b0);
        check_eq("fe_pulse",    fe_total - f0, 1);
        check_eq("fe_nostrobe", strobe_total - s0, 0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        check_eq("fe_count", strobe_total - s0, 1);
        check_eq("fe_data",  last_data, 32'h1122_3344);
        check_eq("fe_com",   bus.ComActive, 32'h1);

        // Timeout drops the partial word and the session
        do_reset();
        s0 = strobe_total;
        send_word(32'hFAB0_FAB1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_clks(4000);
        check_eq("to_before", bus.ComActive, 32'h1);
        wait_clks(200);
        check_eq("to_after",  bus.ComActive, 32'h0);
        send_word(32'h0102_0304);
        check_eq("to_nostrobe", strobe_total - s0, 0);
        check_eq("to_com_stay", bus.ComActive, 32'h0);

        // Short low glitch
        l0 = led_rises; f0 = fe_total;
        bus.Rx = 1'b0;
        wait_clks(2);
        bus.Rx = 1'b1;
        wait_clks(30);
        check_eq("gl_led",    led_rises - l0, 1);
        check_eq("gl_fe",     fe_total - f0, 0);
        check_eq("gl_strobe", strobe_total - s0, 0);
        check_eq("gl_ledoff", bus.ReceiveLED, 32'h0);

        // Reset mid-word, then resync
        do_reset();
        s0 = strobe_total;
        send_word(32'hFAB0_FAB1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        do_reset();
        check_eq("rm_com",      bus.ComActive, 32'h0);
        check_eq("rm_nostrobe", strobe_total - s0, 0);
        send_word(32'hFAB0_FAB1);
        send_word(32'hDEAD_BEEF);
        check_eq("rm_count", strobe_total - s0, 1);
        check_eq("rm_data",  last_data, 32'hDEAD_BEEF);

        check_eq("strobe_width", strobe_wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

`default_nettype wire
